// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: RAW detect, forwarding, stall/flush sequencing
module hazard_ctrl_unit #(
    parameter  int NREG      = 32,
    parameter  int FWD_EN    = 1,
    parameter  int LOAD_LAT  = 1,
    parameter  int FLUSH_CYC = 2,
    parameter  int PREDICT   = 0,
    parameter  int CW        = 16,
    localparam int RW        = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic          id_branch,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] mem_rd,
    input  logic          ex_wb,
    input  logic          mem_wb,
    input  logic          ex_load,
    input  logic          str_conflict,
    input  logic          br_resolve,
    input  logic          br_mispredict,
    output logic          pc_freeze,
    output logic          id_ex_bubble,
    output logic          do_flush,
    output logic          resolved,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [2:0]    state_out,
    output logic [CW-1:0] stall_cycles
);

    localparam logic [2:0] S_NORM   = 3'b000;
    localparam logic [2:0] S_CTRL   = 3'b001;
    localparam logic [2:0] S_SSTALL = 3'b010;
    localparam logic [2:0] S_FLUSH  = 3'b011;
    localparam logic [2:0] S_DSTALL = 3'b100;

    localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYC - 1);
    localparam logic       BR_WAIT   = (PREDICT == 0);
    localparam logic       FWD_ON    = (FWD_EN != 0);

    logic [2:0] state, state_nx;
    logic [2:0] cnt, cnt_nx;

    logic ex_ok, mem_ok;
    logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
    logic data_haz;
    logic [2:0] dcnt;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign ex_ok    = ex_wb && (ex_rd != '0);
    assign mem_ok   = mem_wb && (mem_rd != '0);
    assign hit_ex1  = ex_ok && id_use1 && (ex_rd == id_rs1);
    assign hit_ex2  = ex_ok && id_use2 && (ex_rd == id_rs2);
    assign hit_mem1 = mem_ok && id_use1 && (mem_rd == id_rs1);
    assign hit_mem2 = mem_ok && id_use2 && (mem_rd == id_rs2);

    assign fwd_a = !FWD_ON ? 2'b00 :
                   (hit_ex1 && !ex_load) ? 2'b01 :
                   hit_mem1 ? 2'b10 : 2'b00;
    assign fwd_b = !FWD_ON ? 2'b00 :
                   (hit_ex2 && !ex_load) ? 2'b01 :
                   hit_mem2 ? 2'b10 : 2'b00;

    // Without forwarding every RAW stalls until the producer has written back.
    always_comb begin
        data_haz = 1'b0;
        dcnt     = 3'd0;
        if (FWD_ON) begin
            if ((hit_ex1 || hit_ex2) && ex_load) begin
                data_haz = 1'b1;
                dcnt     = LOAD_CNT;
            end
        end else if (hit_ex1 || hit_ex2) begin
            data_haz = 1'b1;
            dcnt     = 3'd1;
        end else if (hit_mem1 || hit_mem2) begin
            data_haz = 1'b1;
            dcnt     = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_NORM;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (br_resolve && br_mispredict) begin
            state_nx = S_FLUSH;
            cnt_nx   = FLUSH_CNT;
        end else begin
            case (state)
                S_NORM: begin
                    if (str_conflict) begin
                        state_nx = S_SSTALL;
                    end else if (data_haz) begin
                        state_nx = S_DSTALL;
                        cnt_nx   = dcnt;
                    end else if (id_branch && BR_WAIT) begin
                        state_nx = S_CTRL;
                    end
                end
                S_CTRL: begin
                    if (br_resolve) state_nx = S_NORM;
                end
                S_SSTALL: begin
                    if (!str_conflict) state_nx = S_NORM;
                end
                S_DSTALL: begin
                    if (cnt == 3'd0) state_nx = S_NORM;
                    else cnt_nx = cnt - 3'd1;
                end
                S_FLUSH: begin
                    if (cnt == 3'd0) state_nx = (id_branch && BR_WAIT) ? S_CTRL : S_NORM;
                    else cnt_nx = cnt - 3'd1;
                end
                default: begin
                    state_nx = S_NORM;
                    cnt_nx   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        resolved     = 1'b0;
        pc_freeze    = 1'b0;
        id_ex_bubble = 1'b0;
        do_flush     = 1'b0;
        case (state)
            S_NORM: resolved = 1'b1;
            S_CTRL, S_SSTALL, S_DSTALL: begin
                pc_freeze    = 1'b1;
                id_ex_bubble = 1'b1;
            end
            S_FLUSH: begin
                pc_freeze = 1'b1;
                do_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out = state;

    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= '0;
        else if (pc_freeze && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit, two parameter sets
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use1, id_use2, id_branch, ex_wb, mem_wb, ex_load;
    logic       str_conflict, br_resolve, br_mispredict;

    logic        pf_a, bb_a, fl_a, rs_a, pf_b, bb_b, fl_b, rs_b;
    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic [2:0]  st_a, st_b;
    logic [3:0]  sc_a;
    logic [15:0] sc_b;

    hazard_ctrl_unit #(.NREG(32), .FWD_EN(1), .LOAD_LAT(2), .FLUSH_CYC(2), .PREDICT(0), .CW(4)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_branch(id_branch), .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wb(ex_wb), .mem_wb(mem_wb),
        .ex_load(ex_load), .str_conflict(str_conflict), .br_resolve(br_resolve),
        .br_mispredict(br_mispredict), .pc_freeze(pf_a), .id_ex_bubble(bb_a), .do_flush(fl_a),
        .resolved(rs_a), .fwd_a(fa_a), .fwd_b(fb_a), .state_out(st_a), .stall_cycles(sc_a));

    hazard_ctrl_unit #(.NREG(32), .FWD_EN(0), .LOAD_LAT(3), .FLUSH_CYC(3), .PREDICT(1), .CW(16)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_branch(id_branch), .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wb(ex_wb), .mem_wb(mem_wb),
        .ex_load(ex_load), .str_conflict(str_conflict), .br_resolve(br_resolve),
        .br_mispredict(br_mispredict), .pc_freeze(pf_b), .id_ex_bubble(bb_b), .do_flush(fl_b),
        .resolved(rs_b), .fwd_a(fa_b), .fwd_b(fb_b), .state_out(st_b), .stall_cycles(sc_b));

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  flags;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: mode names follow the architectural state codes; rem counts remaining cycles.
    localparam int M_NORM = 0, M_CTRL = 1, M_SSTALL = 2, M_FLUSH = 3, M_DSTALL = 4;
    int mode_a = M_NORM, rem_a = 0, sc_ma = 0;
    int mode_b = M_NORM, rem_b = 0, sc_mb = 0;

    function automatic bit hit(logic wb, logic [4:0] rd, logic use_, logic [4:0] rs);
        return wb && (rd != 0) && use_ && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(int fe, bit hex, bit hmem);
        if (fe == 0) return 2'd0;
        if (hex && !ex_load) return 2'd1;
        if (hmem) return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t expect_now(int fe, int mode, int sc);
        exp_t e;
        int m;
        m = mode;
        e.st    = m[2:0];
        e.flags = {mode == M_NORM, mode != M_NORM,
                   mode == M_CTRL || mode == M_SSTALL || mode == M_DSTALL, mode == M_FLUSH};
        e.fa    = fwd_sel(fe, hit(ex_wb, ex_rd, id_use1, id_rs1), hit(mem_wb, mem_rd, id_use1, id_rs1));
        e.fb    = fwd_sel(fe, hit(ex_wb, ex_rd, id_use2, id_rs2), hit(mem_wb, mem_rd, id_use2, id_rs2));
        e.sc    = 16'(sc);
        return e;
    endfunction

    task automatic model_step(input int fe, input int ll, input int fc, input int pr, input int cw,
                              inout int mode, inout int rem, inout int sc);
        bit hex, hmem;
        int stall_len;
        hex  = hit(ex_wb, ex_rd, id_use1, id_rs1) || hit(ex_wb, ex_rd, id_use2, id_rs2);
        hmem = hit(mem_wb, mem_rd, id_use1, id_rs1) || hit(mem_wb, mem_rd, id_use2, id_rs2);
        if (fe != 0) stall_len = (hex && ex_load) ? ll : 0;
        else stall_len = hex ? 2 : (hmem ? 1 : 0);
        if (rst) begin
            mode = M_NORM; rem = 0; sc = 0;
            return;
        end
        if (mode != M_NORM && sc < (1 << cw) - 1) sc++;
        if (br_resolve && br_mispredict) begin
            mode = M_FLUSH; rem = fc;
            return;
        end
        case (mode)
            M_NORM: begin
                if (str_conflict) mode = M_SSTALL;
                else if (stall_len > 0) begin mode = M_DSTALL; rem = stall_len; end
                else if (id_branch && pr == 0) mode = M_CTRL;
            end
            M_CTRL:   if (br_resolve) mode = M_NORM;
            M_SSTALL: if (!str_conflict) mode = M_NORM;
            M_DSTALL: begin rem--; if (rem == 0) mode = M_NORM; end
            M_FLUSH:  begin rem--; if (rem == 0) mode = (id_branch && pr == 0) ? M_CTRL : M_NORM; end
            default:  mode = M_NORM;
        endcase
    endtask

    task automatic tick();
        qa.push_back(expect_now(1, mode_a, sc_ma));
        qb.push_back(expect_now(0, mode_b, sc_mb));
        model_step(1, 2, 2, 0, 4, mode_a, rem_a, sc_ma);
        model_step(0, 3, 3, 1, 16, mode_b, rem_b, sc_mb);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear();
        rst = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
        id_use1 = 0; id_use2 = 0; id_branch = 0; ex_wb = 0; mem_wb = 0; ex_load = 0;
        str_conflict = 0; br_resolve = 0; br_mispredict = 0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t ea, eb;
        forever begin
            @(negedge clk);
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("A.state", 16'(st_a), 16'(ea.st));
                chk("A.flags", 16'({rs_a, pf_a, bb_a, fl_a}), 16'(ea.flags));
                chk("A.fwd", 16'({fa_a, fb_a}), 16'({ea.fa, ea.fb}));
                chk("A.stall_cycles", 16'(sc_a), ea.sc);
                chk("B.state", 16'(st_b), 16'(eb.st));
                chk("B.flags", 16'({rs_b, pf_b, bb_b, fl_b}), 16'(eb.flags));
                chk("B.fwd", 16'({fa_b, fb_b}), 16'({eb.fa, eb.fb}));
                chk("B.stall_cycles", sc_b, eb.sc);
            end
        end
    end

    initial begin : stimulus
        clear();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        clear();
        tick();

        // load-use, then clear
        ex_load = 1; ex_wb = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
        tick(); clear(); repeat (4) tick();

        // ALU forward from EX, then from MEM
        ex_rd = 7; mem_rd = 7; ex_wb = 1; mem_wb = 1; id_rs1 = 7; id_rs2 = 7; id_use1 = 1; id_use2 = 1;
        tick();
        ex_rd = 0;
        tick(); clear(); repeat (4) tick();

        // MEM-only match, then EX match
        mem_rd = 3; mem_wb = 1; id_rs1 = 3; id_use1 = 1;
        tick(); clear(); repeat (3) tick();
        ex_rd = 3; ex_wb = 1; id_rs1 = 3; id_use1 = 1;
        tick(); clear(); repeat (4) tick();

        // branch wait, mispredict after 3 cycles
        id_branch = 1; tick(); clear(); repeat (3) tick();
        br_resolve = 1; br_mispredict = 1; tick(); clear(); repeat (5) tick();

        // mispredict during load-use stall
        ex_load = 1; ex_wb = 1; ex_rd = 9; id_rs2 = 9; id_use2 = 1;
        tick(); clear();
        br_resolve = 1; br_mispredict = 1; tick(); clear(); repeat (5) tick();

        // structural conflict together with a hazard
        str_conflict = 1; ex_load = 1; ex_wb = 1; ex_rd = 4; id_rs1 = 4; id_use1 = 1;
        tick(); clear(); repeat (3) tick();

        // long structural stall saturates the narrow counter, then reset mid-flush
        str_conflict = 1; repeat (20) tick(); clear(); tick();
        br_resolve = 1; br_mispredict = 1; tick(); clear(); tick();
        rst = 1; tick(); clear(); repeat (3) tick();

        for (int i = 0; i < 2000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            id_use1       = ($urandom_range(0, 3) != 0);
            id_use2       = ($urandom_range(0, 3) != 0);
            ex_wb         = ($urandom_range(0, 2) != 0);
            mem_wb        = ($urandom_range(0, 2) != 0);
            ex_load       = ($urandom_range(0, 2) == 0);
            id_branch     = ($urandom_range(0, 6) == 0);
            str_conflict  = ($urandom_range(0, 9) == 0);
            br_resolve    = ($urandom_range(0, 4) == 0);
            br_mispredict = ($urandom_range(0, 1) == 0);
            tick();
        end
        clear();
        tick();

        for (int w = 0; w < 10 && qa.size() > 0; w++) @(negedge clk);
        #1;
        if (qa.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", qa.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
